// File: rtl/ring_counter_ctrl.sv
// Bidirectional one-hot ring / Johnson counter with variable rotate step, parallel load and wrap pulse.
// Defining RING_CTR_SELFHEAL_EN makes illegal states recover to the reset value and pulse err.
module ring_counter_ctrl #(
    parameter  int WIDTH    = 8,
    parameter  int JOHNSON  = 0,
    parameter  int INIT_POS = WIDTH - 1,
    localparam int SW       = $clog2(WIDTH)
) (
    input  logic             clock0,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SW-1:0]    step,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [SW-1:0]    pos,
    output logic             wrap,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [WIDTH-1:0] RESET_OUT = (JOHNSON != 0) ? '0 : (WIDTH'(1) << INIT_POS);
    localparam logic [SW-1:0]    RESET_POS = (JOHNSON != 0) ? '0 : SW'(INIT_POS);
    localparam logic [SW:0]      W_EXT     = (SW + 1)'(WIDTH);

    logic [WIDTH-1:0] r_out;
    logic [SW-1:0]    r_pos;
    logic             r_wrap;
    logic             r_err;

    logic [SW:0]      w_stepExt;
    logic [SW:0]      w_s;
    logic [SW:0]      w_posExt;
    logic [SW:0]      w_posSum;
    logic             w_wrapL;
    logic             w_wrapR;
    logic [SW-1:0]    w_posL;
    logic [SW-1:0]    w_posR;
    logic [WIDTH-1:0] w_rotL;
    logic [WIDTH-1:0] w_rotR;
    logic [WIDTH-1:0] w_johnL;
    logic [WIDTH-1:0] w_johnR;
    logic [SW-1:0]    w_lowIdx;
    logic             w_heal;
    logic [WIDTH-1:0] w_nextOut;
    logic [SW-1:0]    w_nextPos;
    logic             w_nextWrap;
    logic             w_nextErr;

    // step < 2^SW < 2*WIDTH, so a single conditional subtract gives step mod WIDTH
    assign w_stepExt = {1'b0, step};
    assign w_s       = (w_stepExt >= W_EXT) ? (w_stepExt - W_EXT) : w_stepExt;
    assign w_posExt  = {1'b0, r_pos};
    assign w_posSum  = w_posExt + w_s;
    assign w_wrapL   = (w_posSum >= W_EXT);
    assign w_wrapR   = (w_posExt < w_s);
    assign w_posL    = w_wrapL ? SW'(w_posSum - W_EXT) : SW'(w_posSum);
    assign w_posR    = w_wrapR ? SW'(w_posExt + W_EXT - w_s) : SW'(w_posExt - w_s);

    assign w_rotL  = (r_out << w_s) | (r_out >> (W_EXT - w_s));
    assign w_rotR  = (r_out >> w_s) | (r_out << (W_EXT - w_s));
    assign w_johnL = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
    assign w_johnR = {~r_out[0], r_out[WIDTH-1:1]};

    always_comb begin
        w_lowIdx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (load_val[i]) w_lowIdx = SW'(i);
        end
    end

`ifdef RING_CTR_SELFHEAL_EN
    logic w_legal;
    assign w_legal = (JOHNSON != 0)
                   ? (((r_out & (r_out + WIDTH'(1))) == '0) || ((~r_out & (~r_out + WIDTH'(1))) == '0))
                   : $onehot(r_out);
    assign w_heal  = ~w_legal;
`else
    assign w_heal  = 1'b0;
`endif

    // Recovery outranks en/mode; pos follows arithmetic only and never rescans out
    always_comb begin
        w_nextOut  = r_out;
        w_nextPos  = r_pos;
        w_nextWrap = 1'b0;
        w_nextErr  = 1'b0;
        if (w_heal) begin
            w_nextOut = RESET_OUT;
            w_nextPos = RESET_POS;
            w_nextErr = 1'b1;
        end else if (en) begin
            case (mode_t'(mode))
                MODE_LEFT: begin
                    if (JOHNSON != 0) begin
                        w_nextOut  = w_johnL;
                        w_nextWrap = (w_johnL == '0);
                    end else begin
                        w_nextOut  = w_rotL;
                        w_nextPos  = w_posL;
                        w_nextWrap = w_wrapL;
                    end
                end
                MODE_RIGHT: begin
                    if (JOHNSON != 0) begin
                        w_nextOut  = w_johnR;
                        w_nextWrap = (w_johnR == '0);
                    end else begin
                        w_nextOut  = w_rotR;
                        w_nextPos  = w_posR;
                        w_nextWrap = w_wrapR;
                    end
                end
                MODE_LOAD: begin
                    w_nextOut = load_val;
                    if (JOHNSON == 0) w_nextPos = w_lowIdx;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            r_out  <= RESET_OUT;
            r_pos  <= RESET_POS;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_out  <= w_nextOut;
            r_pos  <= w_nextPos;
            r_wrap <= w_nextWrap;
            r_err  <= w_nextErr;
        end
    end

    assign out  = r_out;
    assign pos  = r_pos;
    assign wrap = r_wrap;
    assign err  = r_err;

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// Directed bench for ring_counter_ctrl: 8-bit ring, 6-bit ring and 4-bit Johnson instances.
// Load-then-rotate expectations follow RING_CTR_SELFHEAL_EN when it is defined for the build.
module tb_ring_counter_ctrl;

    logic clock0 = 1'b0;
    logic reset_n;
    int   compared   = 0;
    int   mismatched = 0;

    always #5 clock0 = ~clock0;

    logic       en8, wrap8, err8;
    logic [1:0] mode8;
    logic [2:0] step8, pos8;
    logic [7:0] load8, out8;

    logic       en6, wrap6, err6;
    logic [1:0] mode6;
    logic [2:0] step6, pos6;
    logic [5:0] load6, out6;

    logic       enJ, wrapJ, errJ;
    logic [1:0] modeJ, stepJ, posJ;
    logic [3:0] loadJ, outJ;

    logic [7:0] expRing [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [3:0] expJohnL[8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic [3:0] expJohnR[8] = '{4'h8, 4'hC, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0};

    ring_counter_ctrl #(.WIDTH(8)) dut8 (
        .clock0(clock0), .reset_n(reset_n), .en(en8), .mode(mode8), .step(step8),
        .load_val(load8), .out(out8), .pos(pos8), .wrap(wrap8), .err(err8)
    );

    ring_counter_ctrl #(.WIDTH(6)) dut6 (
        .clock0(clock0), .reset_n(reset_n), .en(en6), .mode(mode6), .step(step6),
        .load_val(load6), .out(out6), .pos(pos6), .wrap(wrap6), .err(err6)
    );

    ring_counter_ctrl #(.WIDTH(4), .JOHNSON(1)) dutJ (
        .clock0(clock0), .reset_n(reset_n), .en(enJ), .mode(modeJ), .step(stepJ),
        .load_val(loadJ), .out(outJ), .pos(posJ), .wrap(wrapJ), .err(errJ)
    );

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    task automatic test_reset();
        en8 = 1'b0; mode8 = 2'b00; step8 = '0; load8 = '0;
        en6 = 1'b0; mode6 = 2'b00; step6 = '0; load6 = '0;
        enJ = 1'b0; modeJ = 2'b00; stepJ = '0; loadJ = '0;
        reset_n = 1'b0;
        repeat (2) @(posedge clock0);
        #1;
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h80, 3'd7, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset8: got out=%h pos=%0d wrap=%b err=%b want out=80 pos=7 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
        compared++;
        if ({out6, pos6, wrap6, err6} !== {6'h20, 3'd5, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset6: got out=%h pos=%0d wrap=%b err=%b want out=20 pos=5 wrap=0 err=0", out6, pos6, wrap6, err6);
        end
        compared++;
        if ({outJ, posJ, wrapJ, errJ} !== {4'h0, 2'd0, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL resetJ: got out=%h pos=%0d wrap=%b err=%b want out=0 pos=0 wrap=0 err=0", outJ, posJ, wrapJ, errJ);
        end
        reset_n = 1'b1;
        tick();
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h80, 3'd7, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset8_release: got out=%h pos=%0d wrap=%b err=%b want out=80 pos=7 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
    endtask

    task automatic test_ring_rotate();
        en8 = 1'b1; mode8 = 2'b01; step8 = 3'd1;
        for (int i = 0; i < 8; i++) begin
            tick();
            compared++;
            if ({out8, pos8, wrap8, err8} !== {expRing[i], 3'(i), (i == 0), 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL left1[%0d]: got out=%h pos=%0d wrap=%b err=%b want out=%h pos=%0d wrap=%b err=0",
                         i, out8, pos8, wrap8, err8, expRing[i], i, (i == 0));
            end
        end
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h01, 3'd0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL left1_rewrap: got out=%h pos=%0d wrap=%b want out=01 pos=0 wrap=1", out8, pos8, wrap8);
        end
        mode8 = 2'b10; step8 = 3'd3;
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h20, 3'd5, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL right3: got out=%h pos=%0d wrap=%b want out=20 pos=5 wrap=1", out8, pos8, wrap8);
        end
        mode8 = 2'b00;
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h20, 3'd5, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL hold8: got out=%h pos=%0d wrap=%b want out=20 pos=5 wrap=0", out8, pos8, wrap8);
        end
        en8 = 1'b0;
    endtask

    task automatic test_ring_step_w6();
        en6 = 1'b1; mode6 = 2'b10; step6 = 3'd2;
        tick();
        compared++;
        if ({out6, pos6, wrap6} !== {6'h08, 3'd3, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL w6_right2: got out=%h pos=%0d wrap=%b want out=08 pos=3 wrap=0", out6, pos6, wrap6);
        end
        mode6 = 2'b01; step6 = 3'd4;
        tick();
        compared++;
        if ({out6, pos6, wrap6} !== {6'h02, 3'd1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL w6_left4: got out=%h pos=%0d wrap=%b want out=02 pos=1 wrap=1", out6, pos6, wrap6);
        end
        step6 = 3'd0;
        tick();
        compared++;
        if ({out6, pos6, wrap6} !== {6'h02, 3'd1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL w6_step0: got out=%h pos=%0d wrap=%b want out=02 pos=1 wrap=0", out6, pos6, wrap6);
        end
        en6 = 1'b0; step6 = 3'd1;
        tick();
        compared++;
        if ({out6, pos6, wrap6} !== {6'h02, 3'd1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL w6_en0: got out=%h pos=%0d wrap=%b want out=02 pos=1 wrap=0", out6, pos6, wrap6);
        end
        en6 = 1'b1; step6 = 3'd7;
        tick();
        compared++;
        if ({out6, pos6, wrap6} !== {6'h04, 3'd2, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL w6_step7: got out=%h pos=%0d wrap=%b want out=04 pos=2 wrap=0", out6, pos6, wrap6);
        end
        en6 = 1'b0;
    endtask

    task automatic test_johnson();
        enJ = 1'b1; modeJ = 2'b01; stepJ = 2'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            compared++;
            if ({outJ, posJ, wrapJ} !== {expJohnL[i], 2'd0, (i == 7)}) begin
                mismatched++;
                $display("[TB] FAIL johnL[%0d]: got out=%h pos=%0d wrap=%b want out=%h pos=0 wrap=%b",
                         i, outJ, posJ, wrapJ, expJohnL[i], (i == 7));
            end
        end
        modeJ = 2'b10;
        for (int i = 0; i < 8; i++) begin
            tick();
            compared++;
            if ({outJ, posJ, wrapJ} !== {expJohnR[i], 2'd0, (i == 7)}) begin
                mismatched++;
                $display("[TB] FAIL johnR[%0d]: got out=%h pos=%0d wrap=%b want out=%h pos=0 wrap=%b",
                         i, outJ, posJ, wrapJ, expJohnR[i], (i == 7));
            end
        end
        enJ = 1'b0;
    endtask

    task automatic test_load();
        en8 = 1'b1; mode8 = 2'b11; load8 = 8'h10;
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h10, 3'd4, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL load10: got out=%h pos=%0d wrap=%b want out=10 pos=4 wrap=0", out8, pos8, wrap8);
        end
        load8 = 8'h24;
        tick();
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h24, 3'd2, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL load24: got out=%h pos=%0d wrap=%b err=%b want out=24 pos=2 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
        mode8 = 2'b01; step8 = 3'd1;
        tick();
`ifdef RING_CTR_SELFHEAL_EN
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h80, 3'd7, 1'b0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL heal: got out=%h pos=%0d wrap=%b err=%b want out=80 pos=7 wrap=0 err=1", out8, pos8, wrap8, err8);
        end
        mode8 = 2'b00;
        tick();
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h80, 3'd7, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL heal_after: got out=%h pos=%0d wrap=%b err=%b want out=80 pos=7 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
`else
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h48, 3'd3, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL illegal_rot: got out=%h pos=%0d wrap=%b err=%b want out=48 pos=3 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
        mode8 = 2'b00;
        tick();
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h48, 3'd3, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL illegal_hold: got out=%h pos=%0d wrap=%b err=%b want out=48 pos=3 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
`endif
        en8 = 1'b0;
    endtask

    task automatic test_async_reset();
        en8 = 1'b1; mode8 = 2'b11; load8 = 8'h01;
        tick();
        mode8 = 2'b01; step8 = 3'd1;
        tick();
        tick();
        compared++;
        if ({out8, pos8} !== {8'h04, 3'd2}) begin
            mismatched++;
            $display("[TB] FAIL prereset: got out=%h pos=%0d want out=04 pos=2", out8, pos8);
        end
        #3 reset_n = 1'b0;
        #1;
        compared++;
        if ({out8, pos8, wrap8, err8} !== {8'h80, 3'd7, 1'b0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got out=%h pos=%0d wrap=%b err=%b want out=80 pos=7 wrap=0 err=0", out8, pos8, wrap8, err8);
        end
        #1 reset_n = 1'b1;
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h01, 3'd0, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL resume1: got out=%h pos=%0d wrap=%b want out=01 pos=0 wrap=1", out8, pos8, wrap8);
        end
        tick();
        compared++;
        if ({out8, pos8, wrap8} !== {8'h02, 3'd1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL resume2: got out=%h pos=%0d wrap=%b want out=02 pos=1 wrap=0", out8, pos8, wrap8);
        end
        en8 = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        #1;
        test_reset();
        test_ring_rotate();
        test_ring_step_w6();
        test_johnson();
        test_load();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
